// File: rtl/ahb_lite_ram_responder.sv
// AHB-Lite slave backed by a word-wide RAM, with programmable wait states, a
// two-cycle ERROR response and transfer/error counters for the display.
module ahb_lite_ram_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 0,
    parameter bit ERR_ON_OOR  = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [15:0] XFERCOUNT,
    output logic [7:0]  ERRCOUNT
);
    localparam int WORDS = 1 << ADDR_BITS;
    // Only meaningful when WAIT_STATES > 0.
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] idx;
        logic [1:0]           lo;
        logic [2:0]           size;
        logic                 write;
    } req_t;

    state_t               state;
    req_t                 req;
    logic [3:0]           wait_cnt;
    logic [31:0]          mem [WORDS];

    logic                 accept, misalign, oor, req_err, wr_en;
    logic [ADDR_BITS-1:0] haddr_idx, rd_idx;
    logic [3:0]           wr_be;
    logic [31:0]          rd_word, rd_merged;
    logic                 unused_ok;

    assign unused_ok = ^{HBURST, HTRANS[0]};

    // HREADYOUT is high exactly in the states that can take a new address phase.
    assign accept    = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign haddr_idx = HADDR[ADDR_BITS+1:2];
    assign misalign  = (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign oor       = (HADDR >> (ADDR_BITS + 2)) != 32'd0;
    assign req_err   = (HSIZE > 3'd2) || misalign || (ERR_ON_OOR && oor);

    always_comb begin
        wr_be = 4'b0000;
        case (req.size)
            3'd0:    wr_be = 4'b0001 << req.lo;
            3'd1:    wr_be = req.lo[1] ? 4'b1100 : 4'b0011;
            default: wr_be = 4'b1111;
        endcase
    end

    assign wr_en   = (state == S_DATA) && req.write && HRESETn;
    assign rd_idx  = (state == S_WAIT) ? req.idx : haddr_idx;
    assign rd_word = mem[rd_idx];

    // Zero-wait read accepted during a write's data phase sees the new bytes.
    always_comb begin
        rd_merged = rd_word;
        if (wr_en && req.idx == rd_idx) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) rd_merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[req.idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            XFERCOUNT <= '0;
            ERRCOUNT  <= '0;
            wait_cnt  <= '0;
            req       <= '0;
        end else begin
            HRDATA <= '0;
            if (state == S_DATA)
                XFERCOUNT <= XFERCOUNT + 16'd1;
            if (state == S_ERR2 && ERRCOUNT != 8'hFF)
                ERRCOUNT <= ERRCOUNT + 8'd1;

            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_DATA;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                        if (!req.write) HRDATA <= rd_merged;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 share the address-phase decode.
                    if (accept) begin
                        req <= '{idx: haddr_idx, lo: HADDR[1:0], size: HSIZE, write: HWRITE};
                        if (req_err) begin
                            state     <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                            wait_cnt  <= WS_LOAD;
                        end else begin
                            state     <= S_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            if (!HWRITE) HRDATA <= rd_merged;
                        end
                    end else begin
                        state     <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_ram_responder.sv
// Drives two responders (zero-wait/ERR_ON_OOR=1 and 3-wait/aliasing) with an
// AHB-Lite master and scores every data phase against a byte-level memory model.
module tb_ahb_lite_ram_responder;
    localparam int ND  = 2;
    localparam int CAP = 4096;   // bytes for ADDR_BITS=10

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hresetn   [ND];
    logic [31:0] haddr     [ND];
    logic [2:0]  hburst    [ND];
    logic        hsel      [ND];
    logic [2:0]  hsize     [ND];
    logic [1:0]  htrans    [ND];
    logic [31:0] hwdata    [ND];
    logic        hwrite    [ND];
    logic [31:0] hrdata    [ND];
    logic        hreadyout [ND];
    logic        hresp     [ND];
    logic [15:0] xfercount [ND];
    logic [7:0]  errcount  [ND];

    ahb_lite_ram_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .ERR_ON_OOR(1'b1)) u_ws0 (
        .HCLK(clk), .HRESETn(hresetn[0]), .HADDR(haddr[0]), .HBURST(hburst[0]),
        .HSEL(hsel[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HWRITE(hwrite[0]), .HREADY(hreadyout[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .XFERCOUNT(xfercount[0]),
        .ERRCOUNT(errcount[0]));

    ahb_lite_ram_responder #(.ADDR_BITS(10), .WAIT_STATES(3), .ERR_ON_OOR(1'b0)) u_ws3 (
        .HCLK(clk), .HRESETn(hresetn[1]), .HADDR(haddr[1]), .HBURST(hburst[1]),
        .HSEL(hsel[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HWRITE(hwrite[1]), .HREADY(hreadyout[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .XFERCOUNT(xfercount[1]),
        .ERRCOUNT(errcount[1]));

    exp_t        expq [ND][$];
    logic [7:0]  mm   [ND][CAP];
    int          total = 0;
    int          bad   = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit oor_err(input int d);
        return d == 0;
    endfunction

    // ---------------- driver ----------------
    task automatic addr_phase(input int d, input logic [31:0] a, input logic [2:0] sz,
                              input logic wr, input logic [1:0] tr);
        int n;
        hsel[d]   = 1'b1;
        haddr[d]  = a;
        hsize[d]  = sz;
        hwrite[d] = wr;
        htrans[d] = tr;
        hburst[d] = 3'($urandom_range(0, 7));
        n = 0;
        @(negedge clk);
        while (!hreadyout[d]) begin
            n++;
            if (n > 50) begin
                $display("FAIL hready_timeout dut%0d: HREADYOUT low for %0d cycles, required high within 50", d, n);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int d, input logic [31:0] a, input logic [2:0] sz,
                        input logic wr, input logic [31:0] wd);
        exp_t e;
        int   base;
        e.rd    = !wr;
        e.err   = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
                  (oor_err(d) && a >= CAP);
        e.waits = e.err ? 1 : ws_of(d);
        e.data  = 32'd0;
        if (!e.err) begin
            base = int'(a % CAP);
            if (wr) begin
                for (int k = 0; k < (1 << sz); k++)
                    mm[d][base+k] = wd[8*((base+k)%4) +: 8];
            end else begin
                base = base - (base % 4);
                for (int k = 0; k < 4; k++)
                    e.data[8*k +: 8] = mm[d][base+k];
            end
        end
        expq[d].push_back(e);
        addr_phase(d, a, sz, wr, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd2);
        hwdata[d] = wd;
    endtask

    task automatic idle(input int d, input int n);
        hsel[d]   = 1'($urandom_range(0, 1));
        htrans[d] = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd0;
        haddr[d]  = $urandom;
        hwrite[d] = 1'($urandom_range(0, 1));
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input int n);
        hresetn[d] = 1'b0;
        hsel[d]    = 1'b0;
        htrans[d]  = 2'd0;
        repeat (n) @(posedge clk);
        #1;
        hresetn[d] = 1'b1;
    endtask

    task automatic prefill(input int d);
        for (int w = 0; w < 64; w++)
            xfer(d, 32'(w * 4), 3'd2, 1'b1, $urandom);
    endtask

    task automatic random_run(input int d, input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 99);
            sz = (r < 5) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = $urandom_range(0, 255);
            if (r < 90) begin
                if (sz == 3'd1) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
            end
            if (r >= 95) a = a | ($urandom & 32'hFFFF_F000);
            xfer(d, a, sz, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 4) == 0) idle(d, $urandom_range(1, 2));
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d: got 0x%08h, required 0x%08h at %0t", nm, d, act, req, $time);
        end
    endtask

    initial begin
        bit   dph     [ND];
        int   lowcnt  [ND];
        int   rst_cnt [ND];
        int   exp_x   [ND];
        int   exp_e   [ND];
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            dph[d] = 1'b0; lowcnt[d] = 0; rst_cnt[d] = 0; exp_x[d] = 0; exp_e[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!hresetn[d]) begin
                    if (rst_cnt[d] > 0) begin
                        chk("rst_hreadyout", d, 32'(hreadyout[d]), 32'd1);
                        chk("rst_hresp", d, 32'(hresp[d]), 32'd0);
                        chk("rst_hrdata", d, hrdata[d], 32'd0);
                        chk("rst_xfercount", d, 32'(xfercount[d]), 32'd0);
                        chk("rst_errcount", d, 32'(errcount[d]), 32'd0);
                    end
                    rst_cnt[d]++;
                    dph[d] = 1'b0; lowcnt[d] = 0; exp_x[d] = 0; exp_e[d] = 0;
                    expq[d].delete();
                end else begin
                    rst_cnt[d] = 0;
                    chk("xfercount", d, 32'(xfercount[d]), 32'(exp_x[d] & 32'hFFFF));
                    chk("errcount", d, 32'(errcount[d]), 32'((exp_e[d] > 255) ? 255 : exp_e[d]));
                    if (dph[d]) begin
                        if (!hreadyout[d]) begin
                            lowcnt[d]++;
                            if (expq[d].size() > 0)
                                chk("wait_hresp", d, 32'(hresp[d]), 32'(expq[d][0].err));
                            chk("wait_hrdata", d, hrdata[d], 32'd0);
                        end else if (expq[d].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_dphase dut%0d: got a completed data phase, required none", d);
                        end else begin
                            e = expq[d].pop_front();
                            chk("hresp", d, 32'(hresp[d]), 32'(e.err));
                            chk("wait_cycles", d, 32'(lowcnt[d]), 32'(e.waits));
                            chk("hrdata", d, hrdata[d], (e.rd && !e.err) ? e.data : 32'd0);
                            if (e.err) exp_e[d]++;
                            else       exp_x[d]++;
                            lowcnt[d] = 0;
                        end
                    end else begin
                        chk("idle_hreadyout", d, 32'(hreadyout[d]), 32'd1);
                        chk("idle_hresp", d, 32'(hresp[d]), 32'd0);
                        chk("idle_hrdata", d, hrdata[d], 32'd0);
                    end
                    if (hreadyout[d]) dph[d] = hsel[d] && htrans[d][1];
                end
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        for (int d = 0; d < ND; d++) begin
            hresetn[d] = 1'b0; hsel[d] = 1'b0; htrans[d] = 2'd0; haddr[d] = '0;
            hburst[d] = '0; hsize[d] = '0; hwrite[d] = 1'b0; hwdata[d] = '0;
        end
        @(posedge clk);
        #1;

        // zero-wait responder
        do_reset(0, 3);
        xfer(0, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
        xfer(0, 32'h10, 3'd2, 1'b0, $urandom);
        idle(0, 2);
        xfer(0, 32'h20, 3'd2, 1'b1, 32'h1122_3344);
        xfer(0, 32'h21, 3'd0, 1'b1, 32'h0000_AA00);
        xfer(0, 32'h22, 3'd1, 1'b1, 32'h5566_0000);
        xfer(0, 32'h20, 3'd2, 1'b0, 32'h0);
        idle(0, 2);
        xfer(0, 32'h13, 3'd2, 1'b0, 32'h0);
        idle(0, 1);
        xfer(0, 32'h1000, 3'd2, 1'b0, 32'h0);
        idle(0, 3);
        prefill(0);
        random_run(0, 300);
        repeat (260) xfer(0, $urandom, 3'd3, 1'($urandom_range(0, 1)), $urandom);
        idle(0, 4);

        // three-wait aliasing responder
        do_reset(1, 3);
        prefill(1);
        xfer(1, 32'h30, 3'd2, 1'b1, 32'hCAFE_F00D);
        xfer(1, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
        xfer(1, 32'h10, 3'd2, 1'b0, 32'h0);
        idle(1, 1);
        xfer(1, 32'h1000, 3'd2, 1'b0, 32'h0);
        xfer(1, 32'h13, 3'd2, 1'b0, 32'h0);
        idle(1, 5);
        // write abandoned by reset in its wait phase; the model keeps the old word
        addr_phase(1, 32'h30, 3'd2, 1'b1, 2'd2);
        hwdata[1] = 32'h1234_5678;
        hsel[1]   = 1'b0;
        htrans[1] = 2'd0;
        @(posedge clk);
        #1;
        do_reset(1, 2);
        xfer(1, 32'h30, 3'd2, 1'b0, 32'h0);
        idle(1, 5);
        random_run(1, 150);
        idle(1, 6);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
